// File: rtl/sipo_deser_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
package sipo_deser_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_st_t;

  // bit_cnt width; never zero even for tiny words
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// Serial input strobe/sync plus the valid/ready word output of the deserializer.
interface sipo_deser_if #(parameter int WIDTH = sipo_deser_pkg::DEF_WIDTH);
  import sipo_deser_pkg::*;
  localparam int CW = cnt_w(WIDTH);

  logic             sin;
  logic             sin_en;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (output sin, sin_en, sync, dout_ready,
                  input  dout, dout_valid, overrun, bit_cnt);
  modport slave  (input  sin, sin_en, sync, dout_ready,
                  output dout, dout_valid, overrun, bit_cnt);
endinterface

// File: rtl/sipo_deser_mod_counter.sv
// Modulo-MOD counter with async clear, sync clear and enable; flags the wrapping step.
module sipo_deser_mod_counter #(
  parameter int MOD = 4,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sclr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  // sclr wins over a counting step, so a wrap is never reported on a sync edge
  assign wrap = en && !sclr && (cnt == CW'(MOD - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr)              cnt <= '0;
    else if (sclr || wrap) cnt <= '0;
    else if (en)           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sipo_deser.sv
// Deserializer: shift register, word-complete decode and a one-entry output
// buffer with a sticky overrun flag.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         clr,
  sipo_deser_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] shreg, word, dout_r;
  logic [CW-1:0]    cnt;
  logic             done, ovr;
  buf_st_t          st;

  sipo_deser_mod_counter #(.MOD(WIDTH), .CW(CW)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .sclr (bus.sync),
    .en   (bus.sin_en),
    .cnt  (cnt),
    .wrap (done)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign word = {shreg[WIDTH-2:0], bus.sin};
    end else begin : g_lsb
      assign word = {bus.sin, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                   shreg <= '0;
    else if (bus.sync || done) shreg <= '0;
    else if (bus.sin_en)       shreg <= word;
  end

  // A completing word always takes the slot if it is being drained this edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st     <= BUF_EMPTY;
      dout_r <= '0;
      ovr    <= 1'b0;
    end else begin
      case (st)
        BUF_EMPTY: if (done) begin
          dout_r <= word;
          st     <= BUF_FULL;
        end
        BUF_FULL: begin
          if (done) begin
            if (bus.dout_ready) dout_r <= word;
            else                ovr    <= 1'b1;
          end else if (bus.dout_ready) begin
            st <= BUF_EMPTY;
          end
        end
        default: st <= BUF_EMPTY;
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = (st == BUF_FULL);
  assign bus.overrun    = ovr;
  assign bus.bit_cnt    = cnt;
endmodule

// File: tb/tb_sipo_deser.sv
// Drives an MSB-first and an LSB-first deserializer with identical serial
// streams and checks both against a bit-list model with a word scoreboard.
module tb_sipo_deser;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic sin = 1'b0, sin_en = 1'b0, sync = 1'b0, rdy = 1'b0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(4)) ifm ();
  sipo_deser_if #(.WIDTH(4)) ifl ();

  assign ifm.sin = sin;  assign ifm.sin_en = sin_en;
  assign ifm.sync = sync; assign ifm.dout_ready = rdy;
  assign ifl.sin = sin;  assign ifl.sin_en = sin_en;
  assign ifl.sync = sync; assign ifl.dout_ready = rdy;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .clr(clr), .bus(ifm));
  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .clr(clr), .bus(ifl));

  typedef struct {
    logic [3:0] m;
    logic [3:0] l;
  } exp_t;

  typedef struct {
    logic [3:0] bits;   // bits[3] is sent first
    int         gap;
    logic [3:0] exp_m;
    logic [3:0] exp_l;
  } vec_t;

  exp_t sb[$];
  int   nchk = 0, nfail = 0;
  int   m_cnt = 0;
  logic m_ovr = 1'b0;
  logic m_bits [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0;
    m_ovr = 1'b0;
  endtask

  task automatic check_state();
    chk("valid_m", ifm.dout_valid, sb.size() != 0);
    chk("valid_l", ifl.dout_valid, sb.size() != 0);
    chk("ovr_m", ifm.overrun, m_ovr);
    chk("ovr_l", ifl.overrun, m_ovr);
    chk("bitcnt_m", ifm.bit_cnt, m_cnt);
    chk("bitcnt_l", ifl.bit_cnt, m_cnt);
    if (sb.size() != 0) begin
      chk("dout_m", ifm.dout, sb[0].m);
      chk("dout_l", ifl.dout, sb[0].l);
    end
  endtask

  // One clock edge with the currently driven inputs; model updates, then compare.
  task automatic tick();
    logic [3:0] pre_m, pre_l;
    exp_t e;
    logic done;
    pre_m = ifm.dout;
    pre_l = ifl.dout;
    @(posedge clk);
    if (clr) model_reset();
    else begin
      done = !sync && sin_en && (m_cnt == 3);
      if (sb.size() != 0 && rdy) begin
        e = sb.pop_front();
        chk("consume_m", pre_m, e.m);
        chk("consume_l", pre_l, e.l);
      end
      if (sync) m_cnt = 0;
      else if (sin_en) begin
        m_bits[m_cnt] = sin;
        m_cnt = done ? 0 : m_cnt + 1;
      end
      if (done) begin
        if (sb.size() == 0) begin
          for (int i = 0; i < 4; i++) begin
            e.m[3-i] = m_bits[i];
            e.l[i]   = m_bits[i];
          end
          sb.push_back(e);
        end else m_ovr = 1'b1;
      end
    end
    #1;
    check_state();
  endtask

  task automatic strobe(input logic b);
    sin = b; sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      repeat (gap) tick();
      strobe(w[i]);
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{bits: 4'b0100, gap: 0, exp_m: 4'b0100, exp_l: 4'b0010};
    vecs[1] = '{bits: 4'b1110, gap: 1, exp_m: 4'b1110, exp_l: 4'b0111};
    vecs[2] = '{bits: 4'b0010, gap: 0, exp_m: 4'b0010, exp_l: 4'b0100};
    vecs[3] = '{bits: 4'b1001, gap: 2, exp_m: 4'b1001, exp_l: 4'b1001};

    // reset held with strobes toggling
    clr = 1'b1; sin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin_en = i[0];
      tick();
      chk("rst_dout_m", ifm.dout, 4'b0000);
      chk("rst_dout_l", ifl.dout, 4'b0000);
    end
    sin_en = 1'b0; clr = 1'b0;
    tick();

    // table-driven words with a free consumer
    rdy = 1'b1;
    foreach (vecs[k]) begin
      send_word(vecs[k].bits, vecs[k].gap);
      chk("tbl_valid", ifm.dout_valid, 1'b1);
      chk("tbl_dout_m", ifm.dout, vecs[k].exp_m);
      chk("tbl_dout_l", ifl.dout, vecs[k].exp_l);
    end

    // back-pressure: second word dropped
    tick();
    rdy = 1'b0;
    send_word(4'b0100, 0);
    send_word(4'b1110, 0);
    chk("bp_dout_m", ifm.dout, 4'b0100);
    chk("bp_ovr", ifm.overrun, 1'b1);
    rdy = 1'b1;
    tick();
    chk("bp_drain_valid", ifm.dout_valid, 1'b0);
    chk("bp_ovr_sticky", ifm.overrun, 1'b1);

    // sync realigns mid-word, sin ignored on that edge
    strobe(1'b1); strobe(1'b1);
    sync = 1'b1; sin = 1'b1; sin_en = 1'b1;
    tick();
    sync = 1'b0; sin_en = 1'b0;
    chk("sync_cnt", ifm.bit_cnt, 2'd0);
    chk("sync_ovr_kept", ifm.overrun, 1'b1);
    send_word(4'b1010, 0);
    chk("sync_dout_m", ifm.dout, 4'b1010);
    chk("sync_dout_l", ifl.dout, 4'b0101);

    // async clear mid-word, between edges
    tick();
    strobe(1'b1); strobe(1'b1);
    clr = 1'b1;
    model_reset();
    #1;
    chk("aclr_valid", ifm.dout_valid, 1'b0);
    chk("aclr_cnt", ifm.bit_cnt, 2'd0);
    chk("aclr_ovr", ifm.overrun, 1'b0);
    clr = 1'b0;
    tick();
    send_word(4'b1010, 0);
    chk("clr_dout_m", ifm.dout, 4'b1010);
    chk("clr_dout_l", ifl.dout, 4'b0101);

    // buffered word survives sync; then consume + completion on one edge
    tick();
    rdy = 1'b0;
    send_word(4'b0110, 0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_keep_m", ifm.dout, 4'b0110);
    chk("sync_keep_v", ifm.dout_valid, 1'b1);
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    rdy = 1'b1;
    strobe(1'b1);
    chk("same_dout_m", ifm.dout, 4'b1011);
    chk("same_dout_l", ifl.dout, 4'b1101);
    chk("same_valid", ifm.dout_valid, 1'b1);
    chk("same_ovr", ifm.overrun, 1'b0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
